// File: rtl/cpu_pkg.sv
// Shared types and constants for the core's memory arbitration logic.
package cpu_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY_I,
    ARB_BUSY_D,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

  // Read data returned to the owner of a transaction that timed out.
  localparam logic [31:0] ERR_RDATA = 32'h0;

  // Instruction fetches always read a full word.
  localparam logic [3:0]  FETCH_BE  = 4'hF;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of consecutive data grants made while a fetch waits.
// at_limit tells the arbiter that the fetch port must win the next grant.
module arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt;

  assign at_limit = (cnt == LIMIT);

  // Count data grants that bypass a waiting fetch; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and
// load/store. Data accesses have priority; a starvation counter forces a
// fetch grant after STARVE_LIMIT consecutive data grants. A BUSY phase that
// sees no mem_ready for TIMEOUT_CYCLES cycles is aborted with bus_err.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  // instruction fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  // load/store port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  // status
  output logic        bus_err,
  output logic        stall,
  // memory bus
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  arb_state_t      state;
  arb_state_t      next_state;
  owner_t          owner;
  logic            err_flag;
  logic [TO_W-1:0] tcnt;

  logic            grant_if;
  logic            grant_d;
  logic            timeout_hit;
  logic            starve_at_limit;

  // Fetch is starved while data keeps winning; the counter decides when
  // fetch must be forced through.
  arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .inc      (grant_d & if_req),
    .clr      (grant_if),
    .at_limit (starve_at_limit)
  );

  // The stall depends only on held requests and this cycle's ack.
  assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode, grant selection and state-derived outputs.
  always_comb begin
    next_state  = state;
    grant_if    = 1'b0;
    grant_d     = 1'b0;
    timeout_hit = 1'b0;
    mem_req     = 1'b0;
    if_ack      = 1'b0;
    d_ack       = 1'b0;
    bus_err     = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (if_req && (!d_req || starve_at_limit)) begin
          grant_if   = 1'b1;
          next_state = ARB_BUSY_I;
        end else if (d_req) begin
          grant_d    = 1'b1;
          next_state = ARB_BUSY_D;
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          next_state = ARB_RESP;
        end else if (tcnt == TO_LAST) begin
          timeout_hit = 1'b1;
          next_state  = ARB_RESP;
        end
      end
      ARB_RESP: begin
        if_ack     = (owner == OWN_IF);
        d_ack      = (owner == OWN_D);
        bus_err    = err_flag;
        next_state = ARB_IDLE;
      end
      default: begin
        next_state = ARB_IDLE;
      end
    endcase
  end

  // Latch the winner's request into the memory bus registers at grant time;
  // the fields stay stable for the whole BUSY phase.
  always_ff @(posedge clk) begin
    if (!reset) begin
      owner     <= OWN_IF;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else if (grant_if) begin
      owner     <= OWN_IF;
      mem_we    <= 1'b0;
      mem_addr  <= if_addr;
      mem_wdata <= '0;
      mem_be    <= FETCH_BE;
    end else if (grant_d) begin
      owner     <= OWN_D;
      mem_we    <= d_we;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
      mem_be    <= d_be;
    end
  end

  // Timeout counting and error flag: restarted on every grant, advanced on
  // each BUSY cycle that goes without mem_ready.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tcnt     <= '0;
      err_flag <= 1'b0;
    end else if (grant_if || grant_d) begin
      tcnt     <= '0;
      err_flag <= 1'b0;
    end else if (mem_req && !mem_ready) begin
      if (timeout_hit) begin
        err_flag <= 1'b1;
      end else begin
        tcnt <= tcnt + TO_W'(1);
      end
    end
  end

  // Capture read data for the owner on completion; stores and timeouts
  // return zero. Values hold between acks.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else if (mem_req && (mem_ready || timeout_hit)) begin
      if (owner == OWN_IF) begin
        if_rdata <= mem_ready ? mem_rdata : ERR_RDATA;
      end else begin
        d_rdata  <= (mem_ready && !mem_we) ? mem_rdata : ERR_RDATA;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: reset, single fetch, simultaneous
// requests, starvation bound, store with wait states, timeout and reset
// during a data access.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        bus_err;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .STARVE_LIMIT  (4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .bus_err  (bus_err),
    .stall    (stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  // Inputs change 1 time unit after the rising edge; outputs are read on the
  // falling edge of the same cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0; mem_ready = 1'b0; mem_rdata = '0;
    next_cycle();
    next_cycle();
    sample();
    n_cmp++;
    if ({mem_req, mem_we, mem_be, if_ack, d_ack, bus_err, stall} !== 10'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want %b",
               {mem_req, mem_we, mem_be, if_ack, d_ack, bus_err, stall}, 10'b0);
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, if_rdata, d_rdata});
    end
    next_cycle();
    d_req = 1'b1;
    sample();
    n_cmp++;
    if ({stall, mem_req} !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_stall: got %b want %b", {stall, mem_req}, 2'b10);
    end
    next_cycle();
    d_req = 1'b0;
    reset = 1'b1;
    sample();
    n_cmp++;
    if ({mem_req, stall} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_release: got %b want %b", {mem_req, stall}, 2'b00);
    end
    next_cycle();
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h40; mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
    sample();  // cycle 0
    n_cmp++;
    if ({mem_req, if_ack, stall} !== 3'b001) begin
      n_bad++;
      $display("FAIL fetch_c0: got %b want %b", {mem_req, if_ack, stall}, 3'b001);
    end
    next_cycle();
    sample();  // cycle 1
    n_cmp++;
    if ({mem_req, mem_we, mem_be, if_ack, stall} !== 8'b1_0_1111_0_1) begin
      n_bad++;
      $display("FAIL fetch_c1_ctrl: got %b want %b",
               {mem_req, mem_we, mem_be, if_ack, stall}, 8'b1_0_1111_0_1);
    end
    n_cmp++;
    if ({mem_addr, mem_wdata} !== {32'h40, 32'h0}) begin
      n_bad++;
      $display("FAIL fetch_c1_bus: got %h want %h", {mem_addr, mem_wdata}, {32'h40, 32'h0});
    end
    next_cycle();
    sample();  // cycle 2
    n_cmp++;
    if ({if_ack, d_ack, bus_err, mem_req, stall} !== 5'b10000) begin
      n_bad++;
      $display("FAIL fetch_c2_ack: got %b want %b",
               {if_ack, d_ack, bus_err, mem_req, stall}, 5'b10000);
    end
    n_cmp++;
    if (if_rdata !== 32'h0050_0093) begin
      n_bad++;
      $display("FAIL fetch_c2_rdata: got %h want %h", if_rdata, 32'h0050_0093);
    end
    next_cycle();
    if_req = 1'b0;
    sample();  // cycle 3
    n_cmp++;
    if ({if_ack, mem_req, if_rdata} !== {2'b00, 32'h0050_0093}) begin
      n_bad++;
      $display("FAIL fetch_c3_hold: got %h want %h", {if_ack, mem_req, if_rdata},
               {2'b00, 32'h0050_0093});
    end
    next_cycle();
  endtask

  task automatic test_simultaneous();
    if_req = 1'b1; if_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wdata = '0; d_be = 4'hF;
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
    sample();  // cycle 0
    next_cycle();
    sample();  // cycle 1: data wins
    n_cmp++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h100}) begin
      n_bad++;
      $display("FAIL simul_c1_data: got %h want %h", {mem_req, mem_we, mem_addr}, {2'b10, 32'h100});
    end
    next_cycle();
    sample();  // cycle 2
    n_cmp++;
    if ({d_ack, if_ack, stall, d_rdata} !== {3'b101, 32'hCAFE_0001}) begin
      n_bad++;
      $display("FAIL simul_c2_dack: got %h want %h", {d_ack, if_ack, stall, d_rdata},
               {3'b101, 32'hCAFE_0001});
    end
    next_cycle();
    d_req = 1'b0; mem_rdata = 32'h00A0_0113;
    sample();  // cycle 3: IDLE, fetch granted
    n_cmp++;
    if ({mem_req, d_ack, if_ack, stall} !== 4'b0001) begin
      n_bad++;
      $display("FAIL simul_c3_idle: got %b want %b", {mem_req, d_ack, if_ack, stall}, 4'b0001);
    end
    next_cycle();
    sample();  // cycle 4
    n_cmp++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h80}) begin
      n_bad++;
      $display("FAIL simul_c4_fetch: got %h want %h", {mem_req, mem_addr}, {1'b1, 32'h80});
    end
    next_cycle();
    sample();  // cycle 5
    n_cmp++;
    if ({if_ack, d_ack, if_rdata, d_rdata} !== {2'b10, 32'h00A0_0113, 32'hCAFE_0001}) begin
      n_bad++;
      $display("FAIL simul_c5_iack: got %h want %h", {if_ack, d_ack, if_rdata, d_rdata},
               {2'b10, 32'h00A0_0113, 32'hCAFE_0001});
    end
    next_cycle();
    if_req = 1'b0;
    sample();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    int         ng = 0;
    int         nd = 0;
    int         ni = 0;
    logic [9:0] we_seq = '0;
    if_req = 1'b1; if_addr = 32'h88;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h180; d_wdata = 32'hA5A5_A5A5; d_be = 4'hF;
    mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
    for (int i = 0; i < 30; i++) begin
      sample();
      if (mem_req === 1'b1) begin
        if (ng < 10) we_seq[ng] = mem_we;
        ng++;
      end
      if (d_ack === 1'b1) nd++;
      if (if_ack === 1'b1) ni++;
      next_cycle();
    end
    if_req = 1'b0; d_req = 1'b0;
    n_cmp++;
    if (ng !== 10) begin
      n_bad++;
      $display("FAIL b2b_grants: got %0d want %0d", ng, 10);
    end
    n_cmp++;
    if (we_seq !== 10'b01_1110_1111) begin
      n_bad++;
      $display("FAIL b2b_order: got %b want %b", we_seq, 10'b01_1110_1111);
    end
    n_cmp++;
    if (nd !== 8 || ni !== 2) begin
      n_bad++;
      $display("FAIL b2b_acks: got d=%0d i=%0d want d=8 i=2", nd, ni);
    end
    sample();
    n_cmp++;
    if ({mem_req, if_rdata} !== {1'b0, 32'h0000_0013}) begin
      n_bad++;
      $display("FAIL b2b_end: got %h want %h", {mem_req, if_rdata}, {1'b0, 32'h0000_0013});
    end
    next_cycle();
  endtask

  task automatic test_store_wait();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h1234_5678; d_be = 4'b0011;
    mem_ready = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    sample();  // cycle 0
    next_cycle();
    for (int i = 1; i <= 4; i++) begin
      mem_ready = (i == 4);
      sample();
      n_cmp++;
      if ({mem_req, mem_we, mem_be, d_ack, mem_addr, mem_wdata} !==
          {7'b1_1_0011_0, 32'h200, 32'h1234_5678}) begin
        n_bad++;
        $display("FAIL store_busy_c%0d: got %h want %h", i,
                 {mem_req, mem_we, mem_be, d_ack, mem_addr, mem_wdata},
                 {7'b1_1_0011_0, 32'h200, 32'h1234_5678});
      end
      next_cycle();
    end
    mem_ready = 1'b0;
    sample();  // cycle 5
    n_cmp++;
    if ({d_ack, if_ack, bus_err, mem_req, d_rdata} !== {4'b1000, 32'h0}) begin
      n_bad++;
      $display("FAIL store_ack: got %h want %h", {d_ack, if_ack, bus_err, mem_req, d_rdata},
               {4'b1000, 32'h0});
    end
    next_cycle();
    d_req = 1'b0;
    sample();
    n_cmp++;
    if ({mem_req, d_ack} !== 2'b00) begin
      n_bad++;
      $display("FAIL store_idle: got %b want %b", {mem_req, d_ack}, 2'b00);
    end
    next_cycle();
  endtask

  task automatic test_timeout();
    int bad_busy = 0;
    if_req = 1'b1; if_addr = 32'h3000; mem_ready = 1'b0; mem_rdata = 32'h7777_7777;
    sample();  // cycle 0
    next_cycle();
    for (int i = 1; i <= 64; i++) begin
      sample();
      if (mem_req !== 1'b1 || if_ack !== 1'b0 || bus_err !== 1'b0 || mem_addr !== 32'h3000)
        bad_busy++;
      next_cycle();
    end
    n_cmp++;
    if (bad_busy !== 0) begin
      n_bad++;
      $display("FAIL timeout_busy: got %0d bad cycles want 0", bad_busy);
    end
    sample();  // cycle 65
    n_cmp++;
    if ({if_ack, bus_err, d_ack, mem_req, if_rdata} !== {4'b1100, 32'h0}) begin
      n_bad++;
      $display("FAIL timeout_ack: got %h want %h", {if_ack, bus_err, d_ack, mem_req, if_rdata},
               {4'b1100, 32'h0});
    end
    next_cycle();
    if_req = 1'b0;
    sample();  // cycle 66
    n_cmp++;
    if ({if_ack, bus_err, mem_req} !== 3'b000) begin
      n_bad++;
      $display("FAIL timeout_idle: got %b want %b", {if_ack, bus_err, mem_req}, 3'b000);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 32'h44;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_be = 4'hF;
    mem_ready = 1'b0; mem_rdata = 32'h00C0_0193;
    sample();  // cycle 0
    next_cycle();
    sample();  // cycle 1
    n_cmp++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h400}) begin
      n_bad++;
      $display("FAIL rmid_busy: got %h want %h", {mem_req, mem_we, mem_addr}, {2'b10, 32'h400});
    end
    next_cycle();
    reset = 1'b0;
    sample();  // cycle 2: reset not yet sampled
    n_cmp++;
    if (mem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_sync: got %b want %b", mem_req, 1'b1);
    end
    next_cycle();
    reset = 1'b1; d_req = 1'b0;
    sample();  // cycle 3
    n_cmp++;
    if ({mem_req, d_ack, if_ack, bus_err, stall, mem_addr} !== {5'b00001, 32'h0}) begin
      n_bad++;
      $display("FAIL rmid_abort: got %h want %h", {mem_req, d_ack, if_ack, bus_err, stall, mem_addr},
               {5'b00001, 32'h0});
    end
    next_cycle();
    mem_ready = 1'b1;
    sample();  // cycle 4
    n_cmp++;
    if ({mem_req, mem_we, mem_be, mem_addr} !== {6'b10_1111, 32'h44}) begin
      n_bad++;
      $display("FAIL rmid_fetch: got %h want %h", {mem_req, mem_we, mem_be, mem_addr},
               {6'b10_1111, 32'h44});
    end
    next_cycle();
    sample();  // cycle 5
    n_cmp++;
    if ({if_ack, d_ack, bus_err, if_rdata} !== {3'b100, 32'h00C0_0193}) begin
      n_bad++;
      $display("FAIL rmid_iack: got %h want %h", {if_ack, d_ack, bus_err, if_rdata},
               {3'b100, 32'h00C0_0193});
    end
    next_cycle();
    if_req = 1'b0; mem_ready = 1'b0;
    sample();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_back_to_back();
    test_store_wait();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t exceeded limit 100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch port and the load/store port of the pipelined core.
- Accepts held-request/ack transactions from both requesters and serialises them onto a ready-based memory bus.
- Data accesses have priority, with a starvation bound for fetch.
- Produces a pipeline stall signal and a bus-error pulse on memory timeout.

Parameters:
- STARVE_LIMIT, 4: max consecutive data grants while a fetch waits; at the limit, fetch is forced next.
- TIMEOUT_CYCLES, 64: BUSY cycles without mem_ready before the transaction is aborted with error.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetched instruction; valid when if_ack=1
- if_ack  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_be  in  4  store byte enables
- d_rdata  out  32  load data; valid when d_ack=1
- d_ack  out  1  one-cycle completion pulse for data
- bus_err  out  1  pulses with the ack of a timed-out transaction
- stall  out  1  pipeline stall
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_be  out  4  memory byte enables
- mem_ready  in  1  memory completion; mem_rdata valid the same cycle
- mem_rdata  in  32  memory read data

Behaviour:
- Reset:
  - Applies when reset=0 at a clk edge, including mid-transaction.
  - State goes to ARB_IDLE. Starve and timeout counters go to 0.
  - All outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_ack, d_ack, bus_err, if_rdata, d_rdata. stall is 0 when no request is asserted.
  - An in-flight memory access is abandoned; the memory must tolerate mem_req dropping.
- FSM states: ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D, ARB_RESP.
- ARB_IDLE:
  - Samples requests and picks a winner:
    - Fetch wins if if_req=1 and (d_req=0 or starve_cnt==STARVE_LIMIT).
    - Otherwise data wins if d_req=1.
  - Latches the winner's addr, we, wdata and be into mem_* registers.
  - Fetch grants use mem_we=0, mem_be=4'hF, mem_wdata=0.
  - Moves to the matching BUSY state.
- ARB_BUSY_x:
  - mem_req=1 with registered fields held stable.
  - On mem_ready=1: captures mem_rdata, sets owner rdata and moves to ARB_RESP.
  - For stores, d_rdata is driven as 0.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 without mem_ready: moves to ARB_RESP with error flagged and owner rdata=32'h0000_0000.
- ARB_RESP:
  - Owner ack=1 for exactly one cycle. bus_err=1 if the transaction was flagged.
  - mem_req=0. Next state is ARB_IDLE.
- Latency:
  - Request seen in IDLE at cycle 0 → BUSY from cycle 1 → mem_ready at cycle k≥1 → ack at cycle k+1 → IDLE at k+2.
  - Zero-wait memory gives a 2-cycle request-to-ack latency and one transaction per 3 cycles.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on a data grant while if_req=1.
  - Clears on a fetch grant.
  - Unchanged on a data grant with if_req=0.
- Simultaneous requests: each is served in turn. The loser keeps its request held and is granted at the next IDLE.
- stall = (if_req & ~if_ack) | (d_req & ~d_ack), combinational.
- Protocol rules:
  - A requester drops or renews req the cycle after ack.
  - Dropping req before ack is a violation; once granted, the transaction still completes and ack still pulses.
  - Addresses are passed through unaligned; no alignment check.
- rdata outputs hold their last value between acks.

Decomposition:
- cpu_pkg holds:
  - typedef enum arb_state_t {ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D, ARB_RESP}
  - typedef enum owner_t {OWN_IF, OWN_D}
  - localparam ERR_RDATA = 32'h0
  - localparam FETCH_BE = 4'hF
- One sub-module, arb_starve_ctr: a saturating counter with inc, clr and at_limit, parameterised by STARVE_LIMIT.
- FSM, timeout counter and datapath registers live in mem_arbiter.

Test Plan:
- Reset then if_req=1, if_addr=0x40, mem_ready tied 1, mem_rdata=0x00500093 → mem_req cycles 1..1, if_ack=1 with if_rdata=0x00500093 at cycle 2, stall=1 in cycles 0-1.
- Simultaneous if_req and d_req (load 0x100, mem_rdata=0xCAFE0001) → data served first (d_ack at cycle 2), fetch granted at cycle 3 IDLE, if_ack at cycle 5.
- d_req held continuously (back-to-back stores) with if_req=1 and STARVE_LIMIT=4 → exactly 4 data grants, then a fetch grant; starve_cnt returns to 0.
- Store d_addr=0x200, d_wdata=0x12345678, d_be=4'b0011, mem_ready after 3 wait cycles → mem_we=1, mem_be=0011 stable for 4 cycles, d_ack with d_rdata=0.
- mem_ready never asserted, TIMEOUT_CYCLES=64 → ack plus bus_err pulse 65 cycles after grant, rdata=0, FSM back to IDLE.
- reset=0 while in ARB_BUSY_D → next cycle mem_req=0, no ack, state IDLE; a pending fetch is granted normally after reset=1.
